// File: rtl/alu_step_sequencer.sv
// Key-stepped front end for the 4-bit ALU: debounced STEP/MODE keys walk
// through operand A, operand B and op-select loads, then capture and hold the result.

module alu_step_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DB_W            = 19
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_s,
    input  logic sync_vld,
    output logic press
);
    localparam logic [DB_W-1:0] LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            level;
    logic            armed;
    logic [DB_W-1:0] cnt;

    // armed stays low until a real released level is seen, so a key held
    // through reset cannot fire until it is let go and pressed again
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level <= 1'b1;
            armed <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (key_s != level) begin
                if (cnt >= LAST) begin
                    level <= key_s;
                    cnt   <= '0;
                    press <= armed & ~key_s;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
            if (sync_vld && level && key_s)
                armed <= 1'b1;
        end
    end
endmodule

module alu_step_sequencer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DB_W            = 19
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] key_n,
    input  logic [9:0] sw,
    input  logic [8:0] alu_result,
    output logic [3:0] op_a,
    output logic [3:0] op_b,
    output logic [1:0] op_sel,
    output logic [1:0] mode,
    output logic [8:0] result_q,
    output logic       result_valid,
    output logic [2:0] state_o
);
    localparam int NUM_KEYS = 2;

    typedef enum logic [2:0] {
        LOAD_A  = 3'd0,
        LOAD_B  = 3'd1,
        LOAD_OP = 3'd2,
        EXEC    = 3'd3,
        SHOW    = 3'd4
    } state_t;

    state_t              state;
    logic [NUM_KEYS-1:0] key_s1, key_s2;
    logic [9:0]          sw_s1, sw_s2;
    logic [1:0]          vld_pipe;
    logic [NUM_KEYS-1:0] press;
    logic                step_p, mode_p;
    logic                unused_sw;

    // vld_pipe marks when the synchronizers hold real samples rather than reset values
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_s1   <= '1;
            key_s2   <= '1;
            sw_s1    <= '0;
            sw_s2    <= '0;
            vld_pipe <= '0;
        end else begin
            key_s1   <= key_n;
            key_s2   <= key_s1;
            sw_s1    <= sw;
            sw_s2    <= sw_s1;
            vld_pipe <= {vld_pipe[0], 1'b1};
        end
    end

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        alu_step_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .DB_W           (DB_W)
        ) u_db (
            .clk     (clk),
            .reset_n (reset_n),
            .key_s   (key_s2[g]),
            .sync_vld(vld_pipe[1]),
            .press   (press[g])
        );
    end

    assign step_p    = press[0];
    assign mode_p    = press[1];
    assign unused_sw = ^sw_s2[7:4];
    assign state_o   = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= LOAD_A;
            op_a         <= '0;
            op_b         <= '0;
            op_sel       <= '0;
            mode         <= '0;
            result_q     <= '0;
            result_valid <= 1'b0;
        end else begin
            if (mode_p)
                mode <= mode + 2'd1;
            case (state)
                LOAD_A: if (step_p) begin
                    op_a  <= sw_s2[3:0];
                    state <= LOAD_B;
                end
                LOAD_B: if (step_p) begin
                    op_b  <= sw_s2[3:0];
                    state <= LOAD_OP;
                end
                LOAD_OP: if (step_p) begin
                    op_sel <= sw_s2[9:8];
                    state  <= EXEC;
                end
                EXEC: begin
                    result_q     <= alu_result;
                    result_valid <= 1'b1;
                    state        <= SHOW;
                end
                SHOW: begin
                    // STEP takes priority over MODE when both arrive together
                    if (step_p) begin
                        result_valid <= 1'b0;
                        state        <= LOAD_A;
                    end else if (mode_p) begin
                        result_valid <= 1'b0;
                        state        <= EXEC;
                    end
                end
                default: begin
                    result_valid <= 1'b0;
                    state        <= LOAD_A;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_step_sequencer.sv
// Randomized bench for alu_step_sequencer against a transaction-level model
// of the load/exec/show sequence, with a behavioural ALU stub on alu_result.

module tb_alu_step_sequencer;
    localparam int N = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] key_n;
    logic [9:0] sw;
    logic [8:0] alu_result;
    logic [3:0] op_a, op_b;
    logic [1:0] op_sel, mode;
    logic [8:0] result_q;
    logic       result_valid;
    logic [2:0] state_o;
    logic       force_ovf;

    int vectors = 0;
    int errors  = 0;

    int         m_st;
    logic [3:0] m_a, m_b;
    logic [1:0] m_sel, m_mode;
    logic [8:0] m_res;
    logic       m_vld;

    alu_step_sequencer #(.DEBOUNCE_CYCLES(N), .DB_W(3)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .key_n       (key_n),
        .sw          (sw),
        .alu_result  (alu_result),
        .op_a        (op_a),
        .op_b        (op_b),
        .op_sel      (op_sel),
        .mode        (mode),
        .result_q    (result_q),
        .result_valid(result_valid),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] stub(logic [3:0] a, logic [3:0] b, logic [1:0] s, logic [1:0] m);
        logic [3:0] lg;
        lg = (s == 2'd0) ? (a & b) : (s == 2'd1) ? (a | b) : (s == 2'd2) ? (a ^ b) : ~a;
        case (m)
            2'd0:    return 9'd0;
            2'd1:    return 9'(a) + 9'(b) + 9'(s);
            2'd2:    return 9'(lg);
            default: return {5'd0, s, a < b, a == b};
        endcase
    endfunction

    assign alu_result = force_ovf ? 9'h10F : stub(op_a, op_b, op_sel, mode);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_a = 0; m_b = 0; m_sel = 0; m_mode = 0; m_res = 0; m_vld = 0;
    endtask

    // hold the key(s) low for 12 clocks then release for 12; report EXEC cycles seen
    // and the first sample index at which result_valid / state_o changed
    task automatic press(input bit st, input bit md, output int execs,
                         output int rv_lat, output int st_lat);
        logic [2:0] st0;
        execs = 0; rv_lat = -1; st_lat = -1;
        @(negedge clk);
        st0   = state_o;
        key_n = {~md, ~st};
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (state_o == 3'd3) execs++;
            if (rv_lat < 0 && result_valid === 1'b1) rv_lat = i;
            if (st_lat < 0 && state_o !== st0) st_lat = i;
        end
        key_n = 2'b11;
        repeat (12) begin
            @(negedge clk);
            if (state_o == 3'd3) execs++;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".state"}, state_o, m_st);
        chk({tag, ".mode"}, mode, m_mode);
        chk({tag, ".op_a"}, op_a, m_a);
        chk({tag, ".op_b"}, op_b, m_b);
        chk({tag, ".op_sel"}, op_sel, m_sel);
        chk({tag, ".result_q"}, result_q, m_res);
        chk({tag, ".valid"}, result_valid, m_vld);
    endtask

    // apply model effect of one STEP/MODE press; returns expected EXEC cycle count
    function automatic int model_press(bit st, bit md);
        logic [1:0] nm;
        int ex;
        ex = 0;
        nm = md ? m_mode + 2'd1 : m_mode;
        if (st) begin
            case (m_st)
                0: begin m_a = sw[3:0]; m_st = 1; end
                1: begin m_b = sw[3:0]; m_st = 2; end
                2: begin
                    m_sel = sw[9:8];
                    m_res = force_ovf ? 9'h10F : stub(m_a, m_b, m_sel, nm);
                    m_st  = 4; m_vld = 1; ex = 1;
                end
                default: begin m_st = 0; m_vld = 0; end
            endcase
        end else if (md && m_st == 4) begin
            m_res = force_ovf ? 9'h10F : stub(m_a, m_b, m_sel, nm);
            ex = 1;
        end
        m_mode = nm;
        return ex;
    endfunction

    task automatic do_press(input string tag, input bit st, input bit md,
                            output int rv_lat, output int st_lat);
        int ex, ex_exp;
        press(st, md, ex, rv_lat, st_lat);
        ex_exp = model_press(st, md);
        chk({tag, ".execs"}, ex, ex_exp);
        check_all(tag);
    endtask

    initial begin
        int rl, sl;
        reset_n = 1'b0; key_n = 2'b11; sw = '0; force_ovf = 1'b0;
        model_reset();
        #23;
        check_all("rst");
        @(negedge clk); reset_n = 1'b1;
        repeat (10) @(negedge clk);
        check_all("rst_rel");

        // full sequence under mode 1, with result latency measured on the last step
        do_press("m1", 0, 1, rl, sl);
        sw = 10'h009; do_press("ldA", 1, 0, rl, sl);
        sw = 10'h007; do_press("ldB", 1, 0, rl, sl);
        sw = 10'h300; do_press("ldOp", 1, 0, rl, sl);
        chk("rv_lat_in_8_10", (rl >= 8 && rl <= 10), 1);

        // step from SHOW, then a bouncing STEP press in LOAD_A
        do_press("toA", 1, 0, rl, sl);
        sw = 10'h005;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            key_n[0] = i[0];
            repeat (2) @(negedge clk);
        end
        key_n[0] = 1'b0;
        sl = -1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (sl < 0 && state_o !== 3'd0) sl = i;
        end
        key_n[0] = 1'b1;
        repeat (12) @(negedge clk);
        void'(model_press(1, 0));
        check_all("bounce");
        chk("bounce_lat_in_6_8", (sl >= 6 && sl <= 8), 1);

        // reach SHOW, then walk mode through the wrap
        sw = 10'h10C; do_press("ldB2", 1, 0, rl, sl);
        sw = 10'h203; do_press("ldOp2", 1, 0, rl, sl);
        for (int i = 0; i < 4; i++) do_press("mwrap", 0, 1, rl, sl);
        do_press("m2", 0, 1, rl, sl);
        do_press("m3", 0, 1, rl, sl);
        do_press("both", 1, 1, rl, sl);

        // overflow capture and hold
        sw = 10'h00F; do_press("ovA", 1, 0, rl, sl);
        sw = 10'h001; do_press("ovB", 1, 0, rl, sl);
        force_ovf = 1'b1;
        sw = 10'h100; do_press("ovOp", 1, 0, rl, sl);
        force_ovf = 1'b0;
        repeat (20) @(negedge clk);
        chk("ovf_hold", result_q, 9'h10F);

        // async reset mid-SHOW with STEP held through release
        #2 key_n[0] = 1'b0; reset_n = 1'b0;
        #1 model_reset();
        check_all("rst_mid");
        @(negedge clk); reset_n = 1'b1;
        repeat (30) @(negedge clk);
        check_all("held_key");
        key_n[0] = 1'b1;
        repeat (12) @(negedge clk);
        sw = 10'h00A; do_press("rearm", 1, 0, rl, sl);

        for (int k = 0; k < 40; k++) begin
            int sel;
            sel = $urandom_range(0, 4);
            sw  = 10'($urandom);
            if (sel == 0)      do_press("rnd", 1, 1, rl, sl);
            else if (sel == 1) do_press("rnd", 0, 1, rl, sl);
            else               do_press("rnd", 1, 0, rl, sl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
